// File: rtl/spi_msg_ctrl_pkg.sv
// Shared definitions for the SPI message sequencer and its tx shift register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_msg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LOAD,
        ST_DATA,
        ST_END
    } state_t;

    localparam logic [7:0] TX_IDLE_DEF  = 8'h00;
    localparam int         MAX_DATA_DEF = 8;

    // Replicate one byte across a 64-bit word (idle fill for the tx register).
    function automatic logic [63:0] fill_bytes(input logic [7:0] b);
        return {8{b}};
    endfunction

endpackage

// File: rtl/spi_tx_shift.sv
// 64-bit read-back register: parallel load, byte-wise right shift, tx_byte = [7:0].
// Latency: load/shift visible on tx_byte one cycle after the control strobe.
// Backpressure: none; clear wins over load, load wins over shift.
module spi_tx_shift
    import spi_msg_ctrl_pkg::*;
#(
    parameter logic [7:0] TX_IDLE = TX_IDLE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [63:0] load_dat,
    input  logic        shift,
    output logic [7:0]  tx_byte
);

    logic [63:0] sreg;

    // Load/shift register; vacated bytes are refilled with the idle pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= fill_bytes(TX_IDLE);
        end else if (clear) begin
            sreg <= fill_bytes(TX_IDLE);
        end else if (load) begin
            sreg <= load_dat;
        end else if (shift) begin
            sreg <= {TX_IDLE, sreg[63:8]};
        end
    end

    assign tx_byte = sreg[7:0];

endmodule

// File: rtl/spi_msg_ctrl.sv
// Frames each chip-select period into a command byte plus data bytes and serves read-back bytes.
// Latency: tx_byte for data byte 0 valid 2 cycles after the command rx_valid; msg_end 1 cycle after ssel_n rises.
// Backpressure: none; every rx_valid strobe is consumed, excess data bytes are counted and dropped.
module spi_msg_ctrl
    import spi_msg_ctrl_pkg::*;
#(
    parameter int         MAX_DATA = MAX_DATA_DEF,
    parameter logic [7:0] TX_IDLE  = TX_IDLE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ssel_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  tx_byte,
    output logic [7:0]  spi_cmd,
    output logic [63:0] spi_rxdata,
    output logic        spi_msg_end,
    input  logic [63:0] spi_txdata,
    input  logic        spi_txdata_valid,
    output logic        busy,
    output logic        overflow
);

    localparam int            CW      = $clog2(MAX_DATA + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_DATA + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic          shift_pend;
    logic          cmd_cap;
    logic          data_cap;
    logic          tx_load;
    logic          tx_shift;
    logic          tx_clear;
    logic [63:0]   tx_load_dat;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes; a byte arriving with ssel_n rising is taken before END.
    always_comb begin
        state_nxt   = state;
        cmd_cap     = 1'b0;
        data_cap    = 1'b0;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        tx_clear    = 1'b0;
        spi_msg_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ssel_n) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (rx_valid) begin
                    cmd_cap   = 1'b1;
                    state_nxt = ST_LOAD;
                end
                if (ssel_n) state_nxt = ST_END;
            end
            ST_LOAD: begin
                // A byte here is a protocol slip: keep it as data, shift the tx register next cycle.
                tx_load   = 1'b1;
                data_cap  = rx_valid;
                state_nxt = ssel_n ? ST_END : ST_DATA;
            end
            ST_DATA: begin
                data_cap = rx_valid;
                tx_shift = rx_valid | shift_pend;
                if (ssel_n) state_nxt = ST_END;
            end
            ST_END: begin
                // busy is only set once a command byte arrived, so empty frames give no strobe.
                spi_msg_end = busy;
                tx_clear    = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Message capture: command, right-shifting data window, saturating byte count, sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_cmd    <= 8'h00;
            spi_rxdata <= 64'h0;
            count      <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            shift_pend <= 1'b0;
        end else begin
            if (cmd_cap) begin
                spi_cmd    <= rx_byte;
                spi_rxdata <= 64'h0;
                count      <= '0;
                overflow   <= 1'b0;
                busy       <= 1'b1;
            end
            if (data_cap) begin
                if (count < CNT_MAX) begin
                    spi_rxdata <= {rx_byte, spi_rxdata[63:8]};
                end else begin
                    overflow <= 1'b1;
                end
                if (count != CNT_SAT) count <= count + 1'b1;
            end
            if (state == ST_END) busy <= 1'b0;
            shift_pend <= (state == ST_LOAD) && rx_valid;
        end
    end

    assign tx_load_dat = spi_txdata_valid ? spi_txdata : fill_bytes(TX_IDLE);

    spi_tx_shift #(
        .TX_IDLE (TX_IDLE)
    ) u_tx_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (tx_clear),
        .load     (tx_load),
        .load_dat (tx_load_dat),
        .shift    (tx_shift),
        .tx_byte  (tx_byte)
    );

endmodule

// File: tb/tb_spi_msg_ctrl.sv
// Scoreboard bench for spi_msg_ctrl: expected messages queued as frames are driven, checked on spi_msg_end.
// Latency: tx_byte sequence checked against the 2-cycle load latency.
// Backpressure: n/a (bench drives strobes with >=3 idle cycles between bytes).
module tb_spi_msg_ctrl;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [63:0] rx;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ssel_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  spi_cmd;
    logic [63:0] spi_rxdata;
    logic        spi_msg_end;
    logic [63:0] spi_txdata;
    logic        spi_txdata_valid;
    logic        busy;
    logic        overflow;

    exp_t       exp_q[$];
    logic [7:0] tx_q[$];
    int         vec_cnt   = 0;
    int         err_cnt   = 0;
    int         msg_seen  = 0;
    int         exp_msgs  = 0;

    always #5 clk = ~clk;

    spi_msg_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .ssel_n           (ssel_n),
        .rx_valid         (rx_valid),
        .rx_byte          (rx_byte),
        .tx_byte          (tx_byte),
        .spi_cmd          (spi_cmd),
        .spi_rxdata       (spi_rxdata),
        .spi_msg_end      (spi_msg_end),
        .spi_txdata       (spi_txdata),
        .spi_txdata_valid (spi_txdata_valid),
        .busy             (busy),
        .overflow         (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One shifter byte strobe followed by the guaranteed idle gap.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd"},  64'(spi_cmd),     64'h0);
        chk({tag, "_rx"},   spi_rxdata,       64'h0);
        chk({tag, "_end"},  64'(spi_msg_end), 64'h0);
        chk({tag, "_tx"},   64'(tx_byte),     64'h0);
        chk({tag, "_busy"}, 64'(busy),        64'h0);
        chk({tag, "_ov"},   64'(overflow),    64'h0);
    endtask

    // Full frame: command + n data bytes (byte i at pay[8i+:8]); optionally checks tx_byte from tx_q.
    task automatic run_msg(input logic [7:0] cmd, input logic [95:0] pay, input int n,
                           input bit chk_tx, input bit close_last);
        exp_t e;
        e.cmd = cmd;
        e.rx  = 64'h0;
        e.ov  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i < 8) e.rx = {pay[8*i +: 8], e.rx[63:8]};
            else       e.ov = 1'b1;
        end
        exp_q.push_back(e);
        exp_msgs++;

        ssel_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = cmd;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        if (chk_tx) chk("tx_before_load", 64'(tx_byte), 64'h0);
        @(posedge clk); #1;
        if (chk_tx) chk("tx_lat2", 64'(tx_byte), 64'(tx_q[0]));
        chk("busy_mid", 64'(busy), 64'h1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (chk_tx) chk("tx_seq", 64'(tx_byte), 64'(tx_q.pop_front()));
            if (close_last && i == n - 1) ssel_n = 1'b1;
            send_byte(pay[8*i +: 8]);
        end
        if (chk_tx) chk("tx_after", 64'(tx_byte), 64'(tx_q.pop_front()));
        ssel_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", 64'(exp_q.size()), 64'h0);
        chk("busy_after", 64'(busy), 64'h0);
    endtask

    // Scoreboard side: every message-end strobe must match the oldest queued frame.
    always @(negedge clk) begin : mon
        exp_t e;
        if (spi_msg_end === 1'b1) begin
            msg_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_msg_end", 64'(spi_msg_end), 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("end_cmd",  64'(spi_cmd),  64'(e.cmd));
                chk("end_rx",   spi_rxdata,    e.rx);
                chk("end_ov",   64'(overflow), 64'(e.ov));
                chk("end_busy", 64'(busy),     64'h1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        ssel_n           = 1'b1;
        rx_valid         = 1'b0;
        rx_byte          = 8'h00;
        spi_txdata       = 64'h0;
        spi_txdata_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // single data byte lands at the top of the window
        run_msg(8'h02, 96'h01, 1, 1'b0, 1'b0);
        chk("t1_rx_lit", spi_rxdata, 64'h0100_0000_0000_0000);

        // full 8-byte payload
        run_msg(8'h10, 96'h8877_6655_4433_2211, 8, 1'b0, 1'b0);
        chk("t2_rx_lit", spi_rxdata, 64'h8877_6655_4433_2211);
        chk("t2_ov", 64'(overflow), 64'h0);

        // 10 bytes: first 8 kept, overflow, count saturates at MAX_DATA+1
        run_msg(8'h10, 96'hAA99_8877_6655_4433_2211, 10, 1'b0, 1'b0);
        chk("t3_rx_lit", spi_rxdata, 64'h8877_6655_4433_2211);
        chk("t3_ov", 64'(overflow), 64'h1);
        chk("t3_count_sat", 64'(dut.count), 64'd9);

        // read-back bytes served LSB first, then idle
        spi_txdata       = 64'hA1B2_C3D4_E5F6_0718;
        spi_txdata_valid = 1'b1;
        tx_q = '{8'h18, 8'h07, 8'hF6, 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00};
        run_msg(8'h20, 96'h3837_3635_3433_3231, 8, 1'b1, 1'b0);

        // no valid read-back data: idle bytes throughout
        spi_txdata_valid = 1'b0;
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_msg(8'h21, 96'h0403_0201, 4, 1'b1, 1'b0);

        // empty chip-select windows, with and without valid read-back
        for (int v = 0; v < 2; v++) begin
            spi_txdata_valid = (v == 0);
            ssel_n = 1'b0;
            repeat (20) begin
                @(negedge clk);
                chk("idle_busy", 64'(busy), 64'h0);
                chk("idle_tx", 64'(tx_byte), 64'h0);
            end
            @(posedge clk); #1;
            ssel_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("idle_no_end", 64'(msg_seen), 64'(exp_msgs));
        end

        // last byte coincides with ssel_n rising: byte still captured
        spi_txdata_valid = 1'b0;
        run_msg(8'h30, 96'hBBAA, 2, 1'b0, 1'b1);

        // strobe while deselected is ignored
        send_byte(8'h77);
        chk("ign_cmd", 64'(spi_cmd), 64'h30);
        chk("ign_rx", spi_rxdata, 64'hBBAA_0000_0000_0000);
        chk("ign_busy", 64'(busy), 64'h0);

        // reset mid-message
        spi_txdata_valid = 1'b1;
        ssel_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h40);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("pre_rst_tx", 64'(tx_byte), 64'hE5);
        chk("pre_rst_busy", 64'(busy), 64'h1);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        ssel_n = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_end", 64'(msg_seen), 64'(exp_msgs));

        // clean frame after reset
        spi_txdata_valid = 1'b0;
        run_msg(8'h50, 96'h0C_0B0A, 3, 1'b0, 1'b0);
        chk("t8_rx_lit", spi_rxdata, 64'h0C0B_0A00_0000_0000);

        chk("sb_empty", 64'(exp_q.size()), 64'h0);
        chk("msg_count", 64'(msg_seen), 64'(exp_msgs));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/spi_msg_ctrl.md
Name: spi_msg_ctrl

Overview:
- Message-level sequencer between the byte-level SPI slave shifter (host MCU link) and the command register decoder.
- Frames each chip-select period into one command byte plus up to MAX_DATA data bytes.
- Presents the command and data to the decoder and pulses a message-end strobe when the frame closes.
- Loads decoder read-back data and serves it byte-by-byte to the shifter for transmission.

Parameters:
- MAX_DATA, 8, maximum data bytes captured per message; further bytes are counted but dropped.
- TX_IDLE, 8'h00, value on tx_byte when no read-back data is loaded.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ssel_n  input  1  SPI chip select, active-low, already synchronised to clk
- rx_valid  input  1  one-cycle strobe: a complete byte was shifted in
- rx_byte  input  8  received byte, valid with rx_valid
- tx_byte  output  8  byte the shifter loads for its next transfer
- spi_cmd  output  8  command byte of the current or last message
- spi_rxdata  output  64  data bytes of the message; newest byte at [63:56]
- spi_msg_end  output  1  one-cycle strobe: message complete
- spi_txdata  input  64  read-back data from the decoder, a function of spi_cmd
- spi_txdata_valid  input  1  spi_txdata is meaningful for spi_cmd
- busy  output  1  high from the command byte until spi_msg_end
- overflow  output  1  sticky: the last message carried more than MAX_DATA bytes

Behaviour:
- Reset values (async): state IDLE; spi_cmd=0; spi_rxdata=0; spi_msg_end=0; tx_byte=TX_IDLE; busy=0; overflow=0; byte counter=0.
- States:
  - IDLE → CMD when ssel_n=0.
  - CMD: first rx_valid does the following, then the state moves to LOAD:
    - spi_cmd<=rx_byte
    - spi_rxdata<=0
    - count<=0
    - overflow<=0
    - busy<=1
  - LOAD: lasts exactly one cycle. spi_cmd is now stable.
    - If spi_txdata_valid, tx shift register<=spi_txdata; otherwise it is filled with TX_IDLE bytes.
    - tx_byte is driven from tx shift register [7:0].
    - Next state is DATA.
  - DATA, on each rx_valid:
    - If count<MAX_DATA: spi_rxdata<={rx_byte, spi_rxdata[63:8]}.
    - Otherwise overflow<=1.
    - count saturates at MAX_DATA+1.
    - Tx shift register shifts right 8, filling with TX_IDLE, so tx_byte advances to the next byte.
  - From CMD, LOAD or DATA, ssel_n=1 → END.
  - END: spi_msg_end=1 for exactly this one cycle if a command byte was received, else 0. busy<=0, tx_byte<=TX_IDLE. Next state is IDLE.
- Net effect on spi_rxdata: an N-byte payload (N≤8) occupies [63:64-8N], with the first data byte lowest. A 1-byte payload is at [63:56]; an 8-byte payload has the first byte at [7:0].
- spi_cmd and spi_rxdata are stable during spi_msg_end and hold until the next command byte.
- Latency:
  - tx_byte for data byte 0 is valid 2 cycles after the command rx_valid.
  - The shifter guarantees ≥3 clk between rx_valid strobes.
- Boundary cases:
  - rx_valid in the same cycle as ssel_n rising: the byte is accepted first, then END.
  - ssel_n low then high with no bytes: no spi_msg_end.
  - rx_valid in the LOAD cycle is a protocol violation. The byte is stored as data, and the tx shift is deferred.
  - ssel_n re-asserted in the END cycle: move to IDLE, then CMD on the next cycle. No byte is lost because rx_valid spacing is ≥3.
  - rx_valid while ssel_n=1 is ignored.
  - reset mid-message: immediate return to IDLE, no spi_msg_end.

Decomposition:
- Shared package: state encoding (IDLE, CMD, LOAD, DATA, END) and TX_IDLE default. Command codes stay with the decoder.
- One natural sub-module: spi_tx_shift, a 64-bit load/shift register that outputs tx_byte.

Test Plan:
- Command 8'h02 + data 8'h01, then ssel_n high → spi_msg_end pulses once; spi_cmd=8'h02; spi_rxdata=64'h0100_0000_0000_0000.
- Command 8'h10 + bytes 11,22,…,88 → spi_rxdata=64'h8877_6655_4433_2211 at spi_msg_end; overflow=0.
- Command 8'h10 + 10 data bytes → spi_rxdata holds the first 8 bytes only; overflow=1; count saturates; one spi_msg_end.
- spi_txdata=64'hA1B2_C3D4_E5F6_0718 with valid=1 for command 8'h20 → tx_byte sequence 18,07,F6,E5,D4,C3,B2,A1, then TX_IDLE.
- ssel_n pulsed low for 20 cycles with no rx_valid → no spi_msg_end, busy stays 0. Same with spi_txdata_valid=0 → tx_byte=TX_IDLE throughout.
- reset asserted after command plus 3 data bytes → all outputs at reset values, no spi_msg_end. A subsequent clean message frames correctly.
